// File: rtl/axi4_slave_mem_if.sv
// AXI4 bus bundle between a master and the axi4_slave_mem slave.
interface axi4_slave_mem_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 slave word memory, one outstanding write and one outstanding read burst.
// Define AXI4_SLAVE_MEM_ERR_EN to enable SLVERR checks (size, wrap length, range, wlast).
module axi4_slave_mem #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input logic             clk,
  input logic             rst,
  axi4_slave_mem_if.slave s_axi
);
  localparam int unsigned OFF    = $clog2(STRB_WIDTH);
  localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ax_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_e w_state_q, w_state_d;
  ax_t      aw_q, aw_d;
  logic [7:0] w_cnt_q, w_cnt_d;
  logic     w_over_q, w_over_d, w_err_q, w_err_d;
  logic     awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0] bresp_q, bresp_d;
  logic     w_we_c, w_beat_err_c;

  r_state_e r_state_q, r_state_d;
  ax_t      ar_q, ar_d;
  logic [7:0] r_cnt_q, r_cnt_d;
  logic     arready_q, rvalid_q, rlast_q, rlast_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0] r_nx_addr_c;
  logic     r_ar_err_c, r_nx_err_c;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, mask;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + step) & mask);
      default: return a + step;
    endcase
  endfunction

  function automatic logic [MEM_AW-1:0] mem_idx(input logic [ADDR_WIDTH-1:0] a);
    return MEM_AW'((32'(a) >> OFF) % MEM_DEPTH);
  endfunction

`ifdef AXI4_SLAVE_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
  function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
      input logic [1:0] burst);
    return (32'(size) > OFF) || (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
  function automatic logic idx_err(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) >> OFF) >= MEM_DEPTH;
  endfunction
  assign w_beat_err_c = burst_err(aw_q.len, aw_q.size, aw_q.burst) || idx_err(aw_q.addr);
  assign r_ar_err_c   = burst_err(s_axi.arlen, s_axi.arsize, s_axi.arburst) || idx_err(s_axi.araddr);
  assign r_nx_err_c   = burst_err(ar_q.len, ar_q.size, ar_q.burst) || idx_err(r_nx_addr_c);
`else
  localparam bit ERR_EN = 1'b0;
  assign w_beat_err_c = 1'b0;
  assign r_ar_err_c   = 1'b0;
  assign r_nx_err_c   = 1'b0;
`endif

  logic unused_c;
  assign unused_c = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                      s_axi.arlock, s_axi.arcache, s_axi.arprot};

  // Write path: beats past len are swallowed until wlast and never stored.
  always_comb begin
    w_state_d = w_state_q;
    aw_d      = aw_q;
    w_cnt_d   = w_cnt_q;
    w_over_d  = w_over_q;
    w_err_d   = w_err_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    w_we_c    = 1'b0;
    unique case (w_state_q)
      W_IDLE: if (s_axi.awvalid && awready_q) begin
        aw_d = '{id: s_axi.awid, addr: s_axi.awaddr, len: s_axi.awlen,
                 size: s_axi.awsize, burst: s_axi.awburst};
        w_cnt_d   = '0;
        w_over_d  = 1'b0;
        w_err_d   = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (s_axi.wvalid && wready_q) begin
        w_we_c    = !w_over_q && !w_beat_err_c;
        aw_d.addr = next_addr(aw_q.addr, aw_q.len, aw_q.size, aw_q.burst);
        w_cnt_d   = w_cnt_q + 8'd1;
        if (!s_axi.wlast && w_cnt_q == aw_q.len) w_over_d = 1'b1;
        if (w_beat_err_c) w_err_d = 1'b1;
        if (s_axi.wlast) begin
          w_state_d = W_RESP;
          bid_d     = aw_q.id;
          bresp_d   = (ERR_EN && (w_err_q || w_beat_err_c || w_over_q || w_cnt_q != aw_q.len))
                      ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: if (s_axi.bready && bvalid_q) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_q      <= '0;
      w_cnt_q   <= '0;
      w_over_q  <= 1'b0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_q      <= aw_d;
      w_cnt_q   <= w_cnt_d;
      w_over_q  <= w_over_d;
      w_err_q   <= w_err_d;
      awready_q <= (w_state_d == W_IDLE);
      wready_q  <= (w_state_d == W_DATA);
      bvalid_q  <= (w_state_d == W_RESP);
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we_c) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi.wstrb[b]) mem[mem_idx(aw_q.addr)][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  assign r_nx_addr_c = next_addr(ar_q.addr, ar_q.len, ar_q.size, ar_q.burst);

  // Read path: the beat register is loaded at the handshake, so it sees pre-write memory.
  always_comb begin
    r_state_d = r_state_q;
    ar_d      = ar_q;
    r_cnt_d   = r_cnt_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    unique case (r_state_q)
      R_IDLE: if (s_axi.arvalid && arready_q) begin
        ar_d = '{id: s_axi.arid, addr: s_axi.araddr, len: s_axi.arlen,
                 size: s_axi.arsize, burst: s_axi.arburst};
        r_cnt_d   = '0;
        rid_d     = s_axi.arid;
        rdata_d   = r_ar_err_c ? '0 : mem[mem_idx(s_axi.araddr)];
        rresp_d   = r_ar_err_c ? RESP_SLVERR : RESP_OKAY;
        rlast_d   = (s_axi.arlen == 8'd0);
        r_state_d = R_DATA;
      end
      R_DATA: if (s_axi.rready && rvalid_q) begin
        if (rlast_q) begin
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          ar_d.addr = r_nx_addr_c;
          r_cnt_d   = r_cnt_q + 8'd1;
          rdata_d   = r_nx_err_c ? '0 : mem[mem_idx(r_nx_addr_c)];
          rresp_d   = r_nx_err_c ? RESP_SLVERR : RESP_OKAY;
          rlast_d   = ((r_cnt_q + 8'd1) == ar_q.len);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      ar_q      <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      ar_q      <= ar_d;
      r_cnt_q   <= r_cnt_d;
      arready_q <= (r_state_d == R_IDLE);
      rvalid_q  <= (r_state_d == R_DATA);
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
endmodule

// File: doc/axi4_slave_mem.md
# axi4_slave_mem

AXI4 slave memory that terminates the master bus driven by the bench's master interface and serves as the DUT behind it. Accepts one write burst and one read burst concurrently (one outstanding per direction) and stores data in an internal word array. Supports FIXED, INCR and WRAP bursts of 1–256 beats, byte strobes and per-transaction ID echo.

## Interface
- ID_WIDTH, 4, AXI ID width
- ADDR_WIDTH, 12, byte address width
- DATA_WIDTH, 32, data bus width (32 or 64)
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- MEM_DEPTH, 1024, number of DATA_WIDTH words
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- s_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}  input  ID_WIDTH,ADDR_WIDTH,8,3,2,1,4,3,1  write address channel; s_axi_awready output 1
- s_axi_w{data,strb,last,valid}  input  DATA_WIDTH,STRB_WIDTH,1,1  write data channel; s_axi_wready output 1
- s_axi_b{id,resp,valid}  output  ID_WIDTH,2,1  write response; s_axi_bready input 1
- s_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}  input  as AW  read address channel; s_axi_arready output 1
- s_axi_r{id,data,resp,last,valid}  output  ID_WIDTH,DATA_WIDTH,2,1,1  read data channel; s_axi_rready input 1

## Operation
- Lock, cache, prot ignored. Word index = addr[ADDR_WIDTH-1:log2(STRB_WIDTH)] modulo MEM_DEPTH.
- Address step per beat: FIXED 0; INCR 2^size; WRAP 2^size, wrapping within a (len+1)·2^size aligned window. Burst 2'b11 treated as INCR.
- Narrow transfers: strobes applied as given; slave does not mask strobes by size.
- Write FSM: W_IDLE (awready=1) -> AW handshake captures id/addr/len/size/burst, beat count=0 -> W_DATA (wready=1). Each W handshake writes bytes with wstrb=1, advances address, increments count. W handshake with wlast=1 -> W_RESP (bvalid=1, bid=captured awid). B handshake -> W_IDLE.
- wlast mismatch: wlast before beat len -> go to W_RESP with SLVERR; beats beyond len without wlast -> accepted, not written, SLVERR latched, exit on wlast.
- Read FSM: R_IDLE (arready=1) -> AR handshake captures fields -> R_DATA. rvalid=1 with rid=captured arid; rlast=1 on beat len. Each R handshake advances address; handshake with rlast -> R_IDLE.
- Same-word read and write in the same cycle: read returns pre-write data.
- resp OKAY (2'b00) unless an error is flagged (see Configuration); SLVERR=2'b10.

## Timing
- Reset: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, rid, bresp, rresp, rdata = 0; FSMs in IDLE. awready/arready rise on first rising clk after rst deasserts. Memory contents not reset.
- rst asserted mid-burst: all outputs return to reset values immediately; burst abandoned; partially written words keep written beats.
- AW handshake cycle N -> wready=1 in N+1. Final W handshake cycle M -> bvalid=1 in M+1; held, with bid/bresp stable, until bready.
- AR handshake cycle N -> rvalid=1 with beat 0 data in N+1. Back-to-back beats: R handshake in cycle K presents next beat in K+1 (no bubbles). rvalid and rdata held stable while rready=0.
- awready=0 outside W_IDLE; arready=0 outside R_IDLE. Write and read paths fully independent.
- No combinational path from any input to any output.

## Configuration
- AXI4_SLAVE_MEM_ERR_EN defined: SLVERR returned for size > log2(STRB_WIDTH), WRAP with len not in {1,3,7,15}, or any word index ≥ MEM_DEPTH during the burst; erroring write beats not stored, erroring read beats return rdata=0; wlast mismatch SLVERR active.
- Undefined: no checks; bresp/rresp always OKAY; out-of-range indices wrap modulo MEM_DEPTH; wlast mismatch still controls FSM exit but responds OKAY.

## Test plan
- INCR write awaddr=0x010, awlen=3, size=2, data 0xA0..0xA3, strb=4'hF; then INCR read same -> rdata A0,A1,A2,A3, rlast on 4th, bresp=rresp=OKAY, bid/rid echo id 5.
- WRAP read araddr=0x038, arlen=3, size=2 -> word addresses 0x038,0x03C,0x030,0x034 in order.
- Write strb=4'b0101 data 0xFFFFFFFF onto 0x11223344 -> readback 0x11FF33FF.
- rready low for 3 cycles mid-burst, bready low 5 cycles -> rdata/rvalid and bvalid/bid held stable, no beats lost.
- With AXI4_SLAVE_MEM_ERR_EN: awsize=3 on 32-bit bus -> bresp=SLVERR, memory unchanged; WRAP arlen=2 -> all rresp=SLVERR, rdata=0.
- rst pulsed during beat 2 of 8-beat write -> awready/wready/bvalid=0 immediately; awready=1 one clk after release; new burst completes OKAY.
